div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
- Consumes the forwarded rs/rt operands (srca2E/srcb2E) and produces a 64-bit {remainder, quotient} that feeds hilo_reg: hi = remainder, lo = quotient.
- While a divide is running it raises stall_req to the hazard unit, which freezes F/D/E and holds start high.

Parameters:
DATA_W  32  operand width; iteration count equals DATA_W

Ports:
clk         input   1         clock; all state changes on rising edge
rst         input   1         asynchronous, active-low reset
start       input   1         divide request; held high by the pipeline until ready is seen
annul       input   1         cancel (E-stage flush / exception); highest priority after reset
signed_div  input   1         1 = DIV (two's complement), 0 = DIVU
opdata1     input   DATA_W    dividend
opdata2     input   DATA_W    divisor
result      output  2*DATA_W  {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}
ready       output  1         result valid, registered
stall_req   output  1         combinational: start & ~ready & ~annul

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE, ready=0, result=0, count=0, internal dividend/divisor/partial-remainder registers=0.
- An in-flight divide is discarded on reset; no output glitches to ready=1.
- States: IDLE, ZERO, ON, DONE.
- IDLE: if start & ~annul at edge N:
  - opdata2==0 -> ZERO.
  - Otherwise -> ON with count=0.
  - Both operands and signed_div are latched; later changes on the inputs are ignored until the next IDLE.
- Signed mode:
  - The absolute values of both operands are latched.
  - quot_neg = opdata1[MSB]^opdata2[MSB]; rem_neg = opdata1[MSB].
- ON: each edge performs one restoring step:
  - Shift {rem, dividend} left 1.
  - Trial-subtract the divisor magnitude from rem using DATA_W+1-bit arithmetic.
  - If the result is non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - count increments.
  - Steps occur at edges N+1..N+DATA_W.
  - At edge N+DATA_W+1 (count==DATA_W): apply the sign fix (two's-complement negate the quotient if quot_neg, the remainder if rem_neg; signed mode only), load result, set ready=1, go to DONE.
- Latency: ready first observed high after edge N+DATA_W+1 (N+33 for DATA_W=32).
- ZERO (divide by zero, architecturally undefined; the decision is fixed here):
  - Next edge loads result=0, ready=1, goes to DONE.
  - ready is high after edge N+1.
- DONE: ready=1 and result held.
  - If start==0 or annul==1, next edge -> IDLE with ready=0; result keeps its last value.
  - If start stays high, DONE is held. A new divide requires start to drop for at least one cycle.
- annul=1 in ON or ZERO: next edge -> IDLE, ready=0, count=0, partial work discarded, result unchanged.
- annul=1 in IDLE: start is ignored.
- Overflow case 0x80000000 / -1 (signed): quotient=0x80000000, remainder=0. No trap.
- Zero dividend with non-zero divisor: takes the normal full latency and gives result=0.
- stall_req:
  - High from the first cycle start is asserted (including the IDLE cycle) until ready=1.
  - Never high while annul=1.
- The datapath writes hilo_reg on ready & hilowriteE. The divider never writes hilo itself.

Test Plan:
- DIVU 100/7, start held -> stall_req high immediately; ready rises after edge N+33; result={32'd2, 32'd14}; drop start -> IDLE, ready=0 next edge.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
- DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero (DIV 5/0) -> ready high after edge N+1, result=64'h0; then a normal 9/3 after dropping start -> lo=3, hi=0 at N'+33.
- annul pulsed during ON at count=10 -> IDLE next edge, ready never asserts, stall_req low during annul; a subsequent start 20/6 completes with lo=3, hi=2 at full latency.
- rst driven low asynchronously mid-ON (count=17) -> ready=0 and result=0 immediately without a clock edge; after release, start 1/1 -> lo=1, hi=0 at N+33.

Source files
------------

// File: rtl/div_unit_if.sv
// Execute-stage divider bus: request side driven by the pipeline,
// result/handshake side driven by div_unit.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  start;
  logic                  annul;
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  stall_req;

  modport master (
    output start, annul, signed_div, opdata1, opdata2,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, annul, signed_div, opdata1, opdata2,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// result = {remainder, quotient}; hi takes the remainder, lo the quotient.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// ZERO  | divisor was zero, result forced to 0 on the next edge
// ON    | one restoring step per edge, DATA_W steps then sign fix
// DONE  | ready high, result held until start drops or annul
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, ZERO, ON, DONE} state_t;

  state_t              stateQ, stateD;
  logic [CNT_W-1:0]    countQ;
  logic [DATA_W-1:0]   quoQ;
  logic [DATA_W-1:0]   remQ;
  logic [DATA_W-1:0]   divisorQ;
  logic                quotNegQ, remNegQ;
  logic [2*DATA_W-1:0] resultQ;
  logic                readyQ;

  logic                accept;
  logic [DATA_W-1:0]   absA, absB;
  logic [DATA_W:0]     remWide, trial;
  logic [DATA_W-1:0]   quoFix, remFix;

  assign accept = bus.start & ~bus.annul;

  // Magnitudes are latched so the core only ever does unsigned steps.
  assign absA = (bus.signed_div && bus.opdata1[DATA_W-1]) ? -bus.opdata1 : bus.opdata1;
  assign absB = (bus.signed_div && bus.opdata2[DATA_W-1]) ? -bus.opdata2 : bus.opdata2;

  // The extra bit catches the carry out of the shifted partial remainder.
  assign remWide = {remQ, quoQ[DATA_W-1]};
  assign trial   = remWide - {1'b0, divisorQ};

  assign quoFix = quotNegQ ? -quoQ : quoQ;
  assign remFix = remNegQ  ? -remQ : remQ;

  assign bus.result    = resultQ;
  assign bus.ready     = readyQ;
  assign bus.stall_req = bus.start & ~readyQ & ~bus.annul;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateD;
  end

  // Next-state decode; annul wins over everything but reset.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (accept) stateD = (bus.opdata2 == '0) ? ZERO : ON;
      ZERO: stateD = bus.annul ? IDLE : DONE;
      ON: begin
        if (bus.annul)               stateD = IDLE;
        else if (countQ == LAST_CNT) stateD = DONE;
      end
      DONE: if (bus.annul || !bus.start) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring steps, sign fix and result hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countQ   <= '0;
      quoQ     <= '0;
      remQ     <= '0;
      divisorQ <= '0;
      quotNegQ <= 1'b0;
      remNegQ  <= 1'b0;
      resultQ  <= '0;
      readyQ   <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          readyQ <= 1'b0;
          if (accept) begin
            quoQ     <= absA;
            divisorQ <= absB;
            remQ     <= '0;
            countQ   <= '0;
            quotNegQ <= bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
            remNegQ  <= bus.signed_div & bus.opdata1[DATA_W-1];
          end
        end
        ZERO: begin
          countQ <= '0;
          if (!bus.annul) begin
            resultQ <= '0;
            readyQ  <= 1'b1;
          end
        end
        ON: begin
          if (bus.annul) begin
            countQ <= '0;
          end else if (countQ == LAST_CNT) begin
            resultQ <= {remFix, quoFix};
            readyQ  <= 1'b1;
            countQ  <= '0;
          end else begin
            countQ <= countQ + CNT_W'(1);
            if (!trial[DATA_W]) begin
              remQ <= trial[DATA_W-1:0];
              quoQ <= {quoQ[DATA_W-2:0], 1'b1};
            end else begin
              remQ <= remWide[DATA_W-1:0];
              quoQ <= {quoQ[DATA_W-2:0], 1'b0};
            end
          end
        end
        DONE: if (bus.annul || !bus.start) readyQ <= 1'b0;
        default: readyQ <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases with literal results and
// latencies, then randomized divides with occasional annul, all shadowed by
// an arithmetic reference model compared every cycle.
module tb_div_unit;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errCnt = 0;
  int   chkCnt = 0;

  div_unit_if #(.DATA_W(DW)) bus();

  div_unit #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Architectural reference: plain / and %, with the fixed corner cases.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges-to-completion timer plus the expected result.
  logic        mReady  = 1'b0;
  logic [63:0] mResult = 64'h0;
  logic [63:0] mPend   = 64'h0;
  int          mLeft   = 0;
  bit          mBusy   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mReady  = 1'b0;
      mResult = 64'h0;
      mLeft   = 0;
      mBusy   = 1'b0;
    end else if (mReady) begin
      if (bus.annul || !bus.start) mReady = 1'b0;
    end else if (mBusy) begin
      if (bus.annul) mBusy = 1'b0;
      else if (mLeft == 1) begin
        mReady  = 1'b1;
        mResult = mPend;
        mBusy   = 1'b0;
      end else mLeft--;
    end else if (bus.start && !bus.annul) begin
      mPend = refDiv(bus.opdata1, bus.opdata2, bus.signed_div);
      mLeft = (bus.opdata2 == 32'h0) ? 1 : DW + 1;
      mBusy = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_ready", {63'h0, bus.ready}, {63'h0, mReady});
    check("cyc_stall", {63'h0, bus.stall_req}, {63'h0, bus.start & ~mReady & ~bus.annul});
    check("cyc_result", bus.result, mResult);
  end

  task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int expEdges, input string nm);
    int edges = 0;
    bit seen  = 1'b0;
    @(posedge clk); #2;
    bus.opdata1 = a; bus.opdata2 = b; bus.signed_div = sgn;
    bus.annul = 1'b0; bus.start = 1'b1;
    #1 check({nm, "_stall"}, {63'h0, bus.stall_req}, 64'h1);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (bus.ready) seen = 1'b1;
      if (edges == 1) begin
        bus.opdata1 = $urandom; bus.opdata2 = $urandom; bus.signed_div = ~sgn;
      end
    end
    check({nm, "_latency"}, 64'(edges - 1), 64'(expEdges));
    check({nm, "_result"}, bus.result, exp);
    @(posedge clk); #2 bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    check({nm, "_drop"}, {63'h0, bus.ready}, 64'h0);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    bit          doAnnul, seen, annulled;
    int          annulAt, edges;

    bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
    bus.opdata1 = '0; bus.opdata2 = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_ready", {63'h0, bus.ready}, 64'h0);
    check("rst_result", bus.result, 64'h0);
    check("rst_stall", {63'h0, bus.stall_req}, 64'h0);
    check("ref_pin_divu", refDiv(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check("ref_pin_div", refDiv(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("ref_pin_div2", refDiv(32'd7, 32'hFFFF_FFFE, 1'b1), {32'h1, 32'hFFFF_FFFD});
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    runDiv(32'd100,        32'd7,          1'b0, {32'd2, 32'd14},               33, "divu_100_7");
    runDiv(32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
    runDiv(32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "div_7_m2");
    runDiv(32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0, 32'hFFFF_FFFF},         33, "divu_max_1");
    runDiv(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0, 32'h8000_0000},         33, "div_ovf");
    runDiv(32'd5,          32'd0,          1'b1, 64'h0,                          1,  "div_by_0");
    runDiv(32'd9,          32'd3,          1'b1, {32'd0, 32'd3},                 33, "div_9_3");
    runDiv(32'd0,          32'd13,         1'b0, 64'h0,                          33, "divu_0_13");

    // annul while idle blocks the request
    @(posedge clk); #2;
    bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; bus.start = 1'b1; bus.annul = 1'b1;
    #1 check("idle_annul_stall", {63'h0, bus.stall_req}, 64'h0);
    repeat (3) @(posedge clk);
    #2 begin bus.start = 1'b0; bus.annul = 1'b0; end
    @(negedge clk) check("idle_annul_ready", {63'h0, bus.ready}, 64'h0);

    // annul mid-divide at count 10
    @(posedge clk); #2;
    bus.opdata1 = 32'd500; bus.opdata2 = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    repeat (11) @(posedge clk);
    #2 bus.annul = 1'b1;
    #1 check("on_annul_stall", {63'h0, bus.stall_req}, 64'h0);
    @(posedge clk); #2 begin bus.annul = 1'b0; bus.start = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk) check("on_annul_ready", {63'h0, bus.ready}, 64'h0);
    runDiv(32'd20, 32'd6, 1'b0, {32'd2, 32'd3}, 33, "divu_20_6");

    // asynchronous reset mid-divide at count 17
    @(posedge clk); #2;
    bus.opdata1 = 32'd1234; bus.opdata2 = 32'd5; bus.signed_div = 1'b0; bus.start = 1'b1;
    repeat (18) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_ready", {63'h0, bus.ready}, 64'h0);
    check("async_rst_result", bus.result, 64'h0);
    @(posedge clk); #2 begin rst = 1'b1; bus.start = 1'b0; end
    runDiv(32'd1, 32'd1, 1'b0, {32'd0, 32'd1}, 33, "divu_1_1");

    // randomized divides, some cancelled part-way
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'h0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
        3: begin a = 32'($urandom_range(0, 100)); b = $urandom; end
        default: begin a = $urandom; b = $urandom; if (b == 0) b = 32'd3; end
      endcase
      sgn     = 1'($urandom_range(0, 1));
      doAnnul = ($urandom_range(0, 5) == 0);
      annulAt = $urandom_range(1, 34);
      @(posedge clk); #2;
      bus.opdata1 = a; bus.opdata2 = b; bus.signed_div = sgn; bus.start = 1'b1;
      seen = 1'b0; annulled = 1'b0; edges = 0;
      for (int i = 0; i < 60 && !seen && !annulled; i++) begin
        @(posedge clk); edges++;
        if (doAnnul && edges == annulAt) begin
          #2 bus.annul = 1'b1;
          @(posedge clk); #2 begin bus.annul = 1'b0; bus.start = 1'b0; end
          annulled = 1'b1;
        end else begin
          @(negedge clk);
          if (bus.ready) seen = 1'b1;
        end
      end
      if (!annulled) check("rnd_done", {63'h0, seen}, 64'h1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #2 bus.start = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
